// File: rtl/pipe_ctl.sv
// Pipeline control unit for the 5-stage core.
// Merges stage stall requests, EX branch redirects and MEM trap/mret
// requests into a thermometer stall vector, flush strobes and PC redirect.
// A three-state FSM (IDLE, WAIT_MEM, FLUSH) sequences trap entry/return
// and raises the CSR write strobes.
// Ports:
//   ck_i, rs_n_i          clock, async active-low reset
//   stall_req_*_i         per-stage stall requests (if/id/ex/mem)
//   branch_redirect_i     EX mispredict, with branch_target_i
//   exception_i, mem_pc_i MEM-stage exception vector and its PC
//   mret_i                MEM-stage mret
//   mtvec_i, mepc_i       trap vector and return PC from CSRs
//   stall_o               stall vector, bit0 pc .. bit5 wb, 1 = stop
//   flush_o               flush all pipeline registers
//   branch_flush_o        flush if_id and id_ex only
//   pc_we_o, new_pc_o     PC redirect strobe and target
//   trap_we_o, mcause_o, mepc_o  CSR trap write strobe and payload
//   mret_o                mret commit strobe
//   stall_cnt_o           wrapping count of cycles with any stall bit set
module pipe_ctl #(
  parameter int unsigned STALL_CNT_W = 32
) (
  input  logic                   ck_i,
  input  logic                   rs_n_i,
  input  logic                   stall_req_if_i,
  input  logic                   stall_req_id_i,
  input  logic                   stall_req_ex_i,
  input  logic                   stall_req_mem_i,
  input  logic                   branch_redirect_i,
  input  logic [31:0]            branch_target_i,
  input  logic [31:0]            exception_i,
  input  logic [31:0]            mem_pc_i,
  input  logic                   mret_i,
  input  logic [31:0]            mtvec_i,
  input  logic [31:0]            mepc_i,
  output logic [5:0]             stall_o,
  output logic                   flush_o,
  output logic                   branch_flush_o,
  output logic                   pc_we_o,
  output logic [31:0]            new_pc_o,
  output logic                   trap_we_o,
  output logic [31:0]            mcause_o,
  output logic [31:0]            mepc_o,
  output logic                   mret_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_MEM = 2'd1;
  localparam logic [1:0] FLUSH    = 2'd2;

  localparam logic [5:0] STALL_MEM = 6'b011111;
  localparam logic [5:0] STALL_EX  = 6'b001111;
  localparam logic [5:0] STALL_ID  = 6'b000111;
  localparam logic [5:0] STALL_IF  = 6'b000011;

  logic [1:0]             state_q, state_d;
  logic [XLEN-1:0]        cause_q, cause_d;
  logic [XLEN-1:0]        pc_q, pc_d;
  logic                   mret_q, mret_d;
  logic [STALL_CNT_W-1:0] cnt_q;
  logic                   trap_req;

  // Index of the lowest set bit, zero-extended.
  function automatic logic [XLEN-1:0] low_idx(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    r = '0;
    for (int i = XLEN - 1; i >= 0; i--) begin
      if (v[i]) r = XLEN'(i);
    end
    return r;
  endfunction

  assign trap_req = (exception_i != '0) || mret_i;

  // State, latched trap context and stall counter.
  always_ff @(posedge ck_i or negedge rs_n_i) begin
    if (!rs_n_i) begin
      state_q <= IDLE;
      cause_q <= '0;
      pc_q    <= '0;
      mret_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      pc_q    <= pc_d;
      mret_q  <= mret_d;
      if (stall_o != '0) cnt_q <= cnt_q + STALL_CNT_W'(1);
    end
  end

  assign stall_cnt_o = cnt_q;

  // Next state and output decode; everything forced low while in reset.
  always_comb begin
    state_d        = state_q;
    cause_d        = cause_q;
    pc_d           = pc_q;
    mret_d         = mret_q;
    stall_o        = '0;
    flush_o        = 1'b0;
    branch_flush_o = 1'b0;
    pc_we_o        = 1'b0;
    new_pc_o       = '0;
    trap_we_o      = 1'b0;
    mcause_o       = '0;
    mepc_o         = '0;
    mret_o         = 1'b0;

    case (state_q)
      IDLE: begin
        if (trap_req) begin
          // Freeze through mem_wb so the trapping instruction never retires.
          stall_o = STALL_MEM;
          cause_d = low_idx(exception_i);
          pc_d    = mem_pc_i;
          mret_d  = mret_i;
          state_d = stall_req_mem_i ? WAIT_MEM : FLUSH;
        end else if (branch_redirect_i && !stall_req_ex_i && !stall_req_mem_i) begin
          branch_flush_o = 1'b1;
          pc_we_o        = 1'b1;
          new_pc_o       = branch_target_i;
        end else if (stall_req_mem_i) begin
          stall_o = STALL_MEM;
        end else if (stall_req_ex_i) begin
          stall_o = STALL_EX;
        end else if (stall_req_id_i) begin
          stall_o = STALL_ID;
        end else if (stall_req_if_i) begin
          stall_o = STALL_IF;
        end
      end
      WAIT_MEM: begin
        stall_o = STALL_MEM;
        if (!stall_req_mem_i) state_d = FLUSH;
      end
      FLUSH: begin
        flush_o = 1'b1;
        pc_we_o = 1'b1;
        if (mret_q) begin
          new_pc_o = mepc_i;
          mret_o   = 1'b1;
        end else begin
          new_pc_o  = mtvec_i;
          trap_we_o = 1'b1;
          mcause_o  = cause_q;
          mepc_o    = pc_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (!rs_n_i) begin
      stall_o        = '0;
      flush_o        = 1'b0;
      branch_flush_o = 1'b0;
      pc_we_o        = 1'b0;
      new_pc_o       = '0;
      trap_we_o      = 1'b0;
      mcause_o       = '0;
      mepc_o         = '0;
      mret_o         = 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_ctl.sv
// Directed self-checking bench for pipe_ctl.
module tb_pipe_ctl;

  logic        ck_i = 1'b0;
  logic        rs_n_i;
  logic        stall_req_if_i, stall_req_id_i, stall_req_ex_i, stall_req_mem_i;
  logic        branch_redirect_i;
  logic [31:0] branch_target_i, exception_i, mem_pc_i, mtvec_i, mepc_i;
  logic        mret_i;
  logic [5:0]  stall_o;
  logic        flush_o, branch_flush_o, pc_we_o, trap_we_o, mret_o;
  logic [31:0] new_pc_o, mcause_o, mepc_o;
  logic [31:0] stall_cnt_o;

  int errors = 0;
  int checks = 0;

  pipe_ctl #(.STALL_CNT_W(32)) dut (
    .ck_i              (ck_i),
    .rs_n_i            (rs_n_i),
    .stall_req_if_i    (stall_req_if_i),
    .stall_req_id_i    (stall_req_id_i),
    .stall_req_ex_i    (stall_req_ex_i),
    .stall_req_mem_i   (stall_req_mem_i),
    .branch_redirect_i (branch_redirect_i),
    .branch_target_i   (branch_target_i),
    .exception_i       (exception_i),
    .mem_pc_i          (mem_pc_i),
    .mret_i            (mret_i),
    .mtvec_i           (mtvec_i),
    .mepc_i            (mepc_i),
    .stall_o           (stall_o),
    .flush_o           (flush_o),
    .branch_flush_o    (branch_flush_o),
    .pc_we_o           (pc_we_o),
    .new_pc_o          (new_pc_o),
    .trap_we_o         (trap_we_o),
    .mcause_o          (mcause_o),
    .mepc_o            (mepc_o),
    .mret_o            (mret_o),
    .stall_cnt_o       (stall_cnt_o)
  );

  always #5 ck_i = ~ck_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare every output against one expected vector.
  task automatic chk_all(input string tag, input logic [5:0] st, input logic fl,
                         input logic bf, input logic pw, input logic [31:0] npc,
                         input logic tw, input logic [31:0] mc, input logic [31:0] mp,
                         input logic mr, input logic [31:0] cnt);
    chk({tag, ".stall"}, 32'(stall_o), 32'(st));
    chk({tag, ".flush"}, 32'(flush_o), 32'(fl));
    chk({tag, ".bflush"}, 32'(branch_flush_o), 32'(bf));
    chk({tag, ".pc_we"}, 32'(pc_we_o), 32'(pw));
    chk({tag, ".new_pc"}, new_pc_o, npc);
    chk({tag, ".trap_we"}, 32'(trap_we_o), 32'(tw));
    chk({tag, ".mcause"}, mcause_o, mc);
    chk({tag, ".mepc"}, mepc_o, mp);
    chk({tag, ".mret"}, 32'(mret_o), 32'(mr));
    chk({tag, ".cnt"}, stall_cnt_o, cnt);
  endtask

  task automatic tick();
    @(posedge ck_i);
    #1;
  endtask

  task automatic clear_in();
    stall_req_if_i    = 1'b0;
    stall_req_id_i    = 1'b0;
    stall_req_ex_i    = 1'b0;
    stall_req_mem_i   = 1'b0;
    branch_redirect_i = 1'b0;
    branch_target_i   = '0;
    exception_i       = '0;
    mem_pc_i          = '0;
    mret_i            = 1'b0;
  endtask

  initial begin
    rs_n_i  = 1'b0;
    mtvec_i = 32'h200;
    mepc_i  = 32'h0;
    clear_in();
    tick(); tick();
    #1 chk_all("reset", 6'b0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 32'd0);

    tick();
    rs_n_i = 1'b1;

    // Stall priority
    stall_req_id_i = 1'b1;
    #1 chk_all("stall_id", 6'b000111, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 32'd0);
    tick();
    stall_req_ex_i = 1'b1;
    #1 chk_all("stall_ex", 6'b001111, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 32'd1);
    tick();
    stall_req_mem_i = 1'b1;
    #1 chk_all("stall_mem", 6'b011111, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 32'd2);
    tick();
    clear_in();
    stall_req_if_i = 1'b1;
    #1 chk_all("stall_if", 6'b000011, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 32'd3);
    tick();
    clear_in();
    #1 chk_all("idle", 6'b0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 32'd4);

    // Branch redirect overrides id stall, blocked by ex stall
    tick();
    branch_redirect_i = 1'b1;
    branch_target_i   = 32'h100;
    stall_req_id_i    = 1'b1;
    #1 chk_all("redir", 6'b0, 0, 1, 1, 32'h100, 0, 32'h0, 32'h0, 0, 32'd4);
    tick();
    stall_req_ex_i = 1'b1;
    #1 chk_all("redir_ex", 6'b001111, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 32'd4);

    // Trap without mem wait; redirect present but outranked
    tick();
    clear_in();
    exception_i       = 32'h4;
    mem_pc_i          = 32'h80;
    branch_redirect_i = 1'b1;
    branch_target_i   = 32'h300;
    #1 chk_all("trap_n", 6'b011111, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 32'd5);
    tick();
    clear_in();
    #1 chk_all("trap_n1", 6'b0, 1, 0, 1, 32'h200, 1, 32'd2, 32'h80, 0, 32'd6);
    tick();
    #1 chk_all("trap_n2", 6'b0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 32'd6);

    // Trap under mem wait, second pulse ignored
    tick();
    exception_i     = 32'h1;
    stall_req_mem_i = 1'b1;
    mem_pc_i        = 32'h90;
    #1 chk_all("wait0", 6'b011111, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 32'd6);
    tick();
    exception_i = 32'h0;
    #1 chk_all("wait1", 6'b011111, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 32'd7);
    tick();
    exception_i = 32'h2;
    mem_pc_i    = 32'hAA;
    #1 chk_all("wait2", 6'b011111, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 32'd8);
    tick();
    clear_in();
    #1 chk_all("wait3", 6'b011111, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 32'd9);
    tick();
    #1 chk_all("wait_fl", 6'b0, 1, 0, 1, 32'h200, 1, 32'd0, 32'h90, 0, 32'd10);
    tick();
    #1 chk_all("wait_end", 6'b0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 32'd10);

    // mret wins over a simultaneous exception
    tick();
    mret_i      = 1'b1;
    exception_i = 32'h8;
    mepc_i      = 32'h44;
    #1 chk_all("mret0", 6'b011111, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 32'd10);
    tick();
    clear_in();
    #1 chk_all("mret1", 6'b0, 1, 0, 1, 32'h44, 0, 32'h0, 32'h0, 1, 32'd11);
    tick();
    #1 chk_all("mret2", 6'b0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 32'd11);

    // Async reset in WAIT_MEM
    tick();
    exception_i     = 32'h1;
    stall_req_mem_i = 1'b1;
    #1 chk_all("rst_w0", 6'b011111, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 32'd11);
    tick();
    exception_i = 32'h0;
    #1 chk_all("rst_w1", 6'b011111, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 32'd12);
    #1 rs_n_i = 1'b0;
    #1 chk_all("rst_async", 6'b0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 32'd0);
    tick();
    clear_in();
    rs_n_i = 1'b1;
    #1 chk_all("rst_rel0", 6'b0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 32'd0);
    tick();
    #1 chk_all("rst_rel1", 6'b0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 32'd0);
    tick();
    #1 chk_all("rst_rel2", 6'b0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
